// File: rtl/axi_lite_rd_arbiter.sv
// Two-manager AXI-Lite read-channel arbiter: round-robin AR grant, one read in flight,
// R response steered combinationally back to the granted manager.
`timescale 1ns/1ps
module axi_lite_rd_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 4
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ID_W-1:0]   m0_ARID,
   input  logic [ADDR_W-1:0] m0_ARADDR,
   input  logic              m0_ARVALID,
   output logic              m0_ARREADY,
   output logic [ID_W-1:0]   m0_RID,
   output logic [DATA_W-1:0] m0_RDATA,
   output logic [1:0]        m0_RRESP,
   output logic              m0_RVALID,
   input  logic              m0_RREADY,
   input  logic [ID_W-1:0]   m1_ARID,
   input  logic [ADDR_W-1:0] m1_ARADDR,
   input  logic              m1_ARVALID,
   output logic              m1_ARREADY,
   output logic [ID_W-1:0]   m1_RID,
   output logic [DATA_W-1:0] m1_RDATA,
   output logic [1:0]        m1_RRESP,
   output logic              m1_RVALID,
   input  logic              m1_RREADY,
   output logic [ID_W-1:0]   s_ARID,
   output logic [ADDR_W-1:0] s_ARADDR,
   output logic              s_ARVALID,
   input  logic              s_ARREADY,
   input  logic [ID_W-1:0]   s_RID,
   input  logic [DATA_W-1:0] s_RDATA,
   input  logic [1:0]        s_RRESP,
   input  logic              s_RVALID,
   output logic              s_RREADY
);

   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

   state_t            state;
   logic              gnt;
   logic              last;
   logic              sel;
   logic              ar_take;
   logic              in_resp;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;
   logic              arvalid_q;

   // Ties alternate away from the last winner; a lone requester always wins.
   always_comb begin
      sel     = (m0_ARVALID && m1_ARVALID) ? ~last : m1_ARVALID;
      ar_take = (state == IDLE) && (m0_ARVALID || m1_ARVALID) && !ARESETn;
      in_resp = (state == RESP);
   end

   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         id_q      <= '0;
         addr_q    <= '0;
         arvalid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_take) begin
                  gnt       <= sel;
                  last      <= sel;
                  id_q      <= sel ? m1_ARID : m0_ARID;
                  addr_q    <= sel ? m1_ARADDR : m0_ARADDR;
                  arvalid_q <= 1'b1;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (s_ARREADY) begin
                  arvalid_q <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (s_RVALID && s_RREADY) state <= IDLE;
            end
            default: begin
               arvalid_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      m0_ARREADY = ar_take && !sel;
      m1_ARREADY = ar_take && sel;

      s_ARVALID  = arvalid_q;
      s_ARID     = id_q;
      s_ARADDR   = addr_q;

      s_RREADY   = in_resp && (gnt ? m1_RREADY : m0_RREADY);

      m0_RVALID  = in_resp && !gnt && s_RVALID;
      m0_RID     = (in_resp && !gnt) ? s_RID   : '0;
      m0_RDATA   = (in_resp && !gnt) ? s_RDATA : '0;
      m0_RRESP   = (in_resp && !gnt) ? s_RRESP : '0;

      m1_RVALID  = in_resp && gnt && s_RVALID;
      m1_RID     = (in_resp && gnt) ? s_RID   : '0;
      m1_RDATA   = (in_resp && gnt) ? s_RDATA : '0;
      m1_RRESP   = (in_resp && gnt) ? s_RRESP : '0;
   end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: table of single reads plus hand sequences
// for contention, back-pressure, AR stall and reset mid-read.
`timescale 1ns/1ps
module tb_axi_lite_rd_arbiter;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b1;
   logic [3:0]  m0_ARID = '0, m1_ARID = '0;
   logic [31:0] m0_ARADDR = '0, m1_ARADDR = '0;
   logic        m0_ARVALID = 1'b0, m1_ARVALID = 1'b0;
   logic        m0_ARREADY, m1_ARREADY;
   logic [3:0]  m0_RID, m1_RID;
   logic [63:0] m0_RDATA, m1_RDATA;
   logic [1:0]  m0_RRESP, m1_RRESP;
   logic        m0_RVALID, m1_RVALID;
   logic        m0_RREADY = 1'b1, m1_RREADY = 1'b1;
   logic [3:0]  s_ARID;
   logic [31:0] s_ARADDR;
   logic        s_ARVALID;
   logic        s_ARREADY = 1'b0;
   logic [3:0]  s_RID = '0;
   logic [63:0] s_RDATA = '0;
   logic [1:0]  s_RRESP = '0;
   logic        s_RVALID = 1'b0;
   logic        s_RREADY;

   int n_chk = 0;
   int n_fail = 0;

   logic [63:0] mem [0:511];

   always #5 ACLK = ~ACLK;

   axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m0_ARID(m0_ARID), .m0_ARADDR(m0_ARADDR), .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
      .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RVALID(m0_RVALID),
      .m0_RREADY(m0_RREADY),
      .m1_ARID(m1_ARID), .m1_ARADDR(m1_ARADDR), .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY),
      .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RVALID(m1_RVALID),
      .m1_RREADY(m1_RREADY),
      .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
      .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RVALID(s_RVALID),
      .s_RREADY(s_RREADY)
   );

   typedef struct {
      int          mgr;
      logic [3:0]  id;
      logic [31:0] addr;
      int          ar_stall;
      logic [63:0] data;
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 4KB subordinate: anything past 0xFFF answers DECERR with zero data.
   task automatic sub_lookup(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
      logic [8:0] idx;
      idx = a[11:3];
      if (a < 32'h1000) begin d = mem[idx]; r = 2'b00; end
      else              begin d = '0;       r = 2'b11; end
   endtask

   task automatic set_ar(input int mgr, input logic v, input logic [3:0] id, input logic [31:0] a);
      if (mgr == 0) begin m0_ARVALID = v; m0_ARID = id; m0_ARADDR = a; end
      else          begin m1_ARVALID = v; m1_ARID = id; m1_ARADDR = a; end
   endtask

   function automatic logic arready(input int mgr);
      return (mgr == 0) ? m0_ARREADY : m1_ARREADY;
   endfunction

   // Called at a negedge with AR inputs set; checks the grant and crosses one rising edge.
   task automatic ar_hs(input int mgr, input string tag);
      #1;
      chk({tag, " arready_win"},  64'(arready(mgr)), 64'd1);
      chk({tag, " arready_lose"}, 64'(arready(1 - mgr)), 64'd0);
      @(posedge ACLK); @(negedge ACLK);
      if (mgr == 0) m0_ARVALID = 1'b0; else m1_ARVALID = 1'b0;
   endtask

   // Runs the ADDR and RESP phases as the subordinate and checks both sides.
   task automatic serve(input int mgr, input logic [3:0] id, input logic [31:0] a,
                        input int ar_stall, input int r_stall,
                        input logic [63:0] exp_d, input logic [1:0] exp_r, input string tag);
      logic [31:0] cap_a;
      logic [3:0]  cap_id;
      logic [63:0] d;
      logic [1:0]  r;
      s_RVALID = 1'b1;
      #1;
      chk({tag, " s_arvalid"}, 64'(s_ARVALID), 64'd1);
      chk({tag, " s_araddr"},  64'(s_ARADDR), 64'(a));
      chk({tag, " s_arid"},    64'(s_ARID), 64'(id));
      chk({tag, " addr_arready"}, 64'({m0_ARREADY, m1_ARREADY}), 64'd0);
      chk({tag, " early_rready"}, 64'(s_RREADY), 64'd0);
      s_RVALID = 1'b0;
      cap_a = s_ARADDR; cap_id = s_ARID;
      for (int i = 0; i < ar_stall; i++) begin
         @(posedge ACLK); @(negedge ACLK); #1;
         chk({tag, " stall_arvalid"}, 64'(s_ARVALID), 64'd1);
         chk({tag, " stall_araddr"},  64'(s_ARADDR), 64'(cap_a));
         chk({tag, " stall_arid"},    64'(s_ARID), 64'(cap_id));
      end
      s_ARREADY = 1'b1;
      @(posedge ACLK); @(negedge ACLK);
      s_ARREADY = 1'b0;
      sub_lookup(cap_a, d, r);
      s_RID = cap_id; s_RDATA = d; s_RRESP = r; s_RVALID = 1'b1;
      if (mgr == 0) m0_RREADY = (r_stall == 0); else m1_RREADY = (r_stall == 0);
      for (int i = 0; i < r_stall; i++) begin
         #1;
         chk({tag, " bp_rready"}, 64'(s_RREADY), 64'd0);
         chk({tag, " bp_rvalid"}, 64'(mgr == 0 ? m0_RVALID : m1_RVALID), 64'd1);
         chk({tag, " bp_other_arready"}, 64'(arready(1 - mgr)), 64'd0);
         @(posedge ACLK); @(negedge ACLK);
      end
      m0_RREADY = 1'b1; m1_RREADY = 1'b1;
      #1;
      if (mgr == 0) begin
         chk({tag, " rvalid"}, 64'(m0_RVALID), 64'd1);
         chk({tag, " rdata"},  m0_RDATA, exp_d);
         chk({tag, " rresp"},  64'(m0_RRESP), 64'(exp_r));
         chk({tag, " rid"},    64'(m0_RID), 64'(id));
         chk({tag, " other_rvalid"}, 64'(m1_RVALID), 64'd0);
         chk({tag, " other_rdata"},  m1_RDATA, 64'd0);
      end else begin
         chk({tag, " rvalid"}, 64'(m1_RVALID), 64'd1);
         chk({tag, " rdata"},  m1_RDATA, exp_d);
         chk({tag, " rresp"},  64'(m1_RRESP), 64'(exp_r));
         chk({tag, " rid"},    64'(m1_RID), 64'(id));
         chk({tag, " other_rvalid"}, 64'(m0_RVALID), 64'd0);
         chk({tag, " other_rdata"},  m0_RDATA, 64'd0);
      end
      chk({tag, " s_rready"}, 64'(s_RREADY), 64'd1);
      @(posedge ACLK); @(negedge ACLK);
      s_RVALID = 1'b0;
      #1;
      chk({tag, " done_rvalid"}, 64'({m0_RVALID, m1_RVALID}), 64'd0);
      chk({tag, " done_arvalid"}, 64'(s_ARVALID), 64'd0);
   endtask

   initial begin
      foreach (mem[i]) mem[i] = '0;
      mem[1]   = 64'hCAFEBAB0F00DFACE;
      mem[2]   = 64'h1122334455667788;
      mem[3]   = 64'h0123456789ABCDEF;
      mem[511] = 64'hDEADBEEF00C0FFEE;

      vecs[0] = '{0, 4'h3, 32'h0000_0008, 0, 64'hCAFEBAB0F00DFACE, 2'b00};
      vecs[1] = '{1, 4'h5, 32'h0000_2000, 0, 64'h0, 2'b11};
      vecs[2] = '{1, 4'hA, 32'h0000_0010, 3, 64'h1122334455667788, 2'b00};
      vecs[3] = '{0, 4'hF, 32'h0000_0FF8, 1, 64'hDEADBEEF00C0FFEE, 2'b00};
      vecs[4] = '{0, 4'h0, 32'h0000_1000, 0, 64'h0, 2'b11};
      vecs[5] = '{1, 4'h9, 32'h0000_0018, 0, 64'h0123456789ABCDEF, 2'b00};

      // Reset state, with requests pending so readies are exercised.
      @(negedge ACLK);
      set_ar(0, 1'b1, 4'h1, 32'h8);
      s_RVALID = 1'b1;
      #1;
      chk("rst arready", 64'({m0_ARREADY, m1_ARREADY}), 64'd0);
      chk("rst s_arvalid", 64'(s_ARVALID), 64'd0);
      chk("rst s_araddr", 64'(s_ARADDR), 64'd0);
      chk("rst s_arid", 64'(s_ARID), 64'd0);
      chk("rst s_rready", 64'(s_RREADY), 64'd0);
      chk("rst rvalid", 64'({m0_RVALID, m1_RVALID}), 64'd0);
      @(negedge ACLK);
      s_RVALID = 1'b0;
      ARESETn = 1'b0;

      // Contention right after reset: m0 first; m0 re-requests against pending m1, m1 wins.
      set_ar(1, 1'b1, 4'h2, 32'h10);
      ar_hs(0, "tie1");
      serve(0, 4'h1, 32'h8, 0, 0, 64'hCAFEBAB0F00DFACE, 2'b00, "tie1_m0");
      set_ar(0, 1'b1, 4'h3, 32'h18);
      ar_hs(1, "tie2");
      serve(1, 4'h2, 32'h10, 0, 0, 64'h1122334455667788, 2'b00, "tie2_m1");
      ar_hs(0, "tie2b");
      serve(0, 4'h3, 32'h18, 0, 0, 64'h0123456789ABCDEF, 2'b00, "tie2_m0");

      // s_RVALID while idle must not be accepted.
      s_RVALID = 1'b1;
      #1;
      chk("idle s_rready", 64'(s_RREADY), 64'd0);
      chk("idle rvalid", 64'({m0_RVALID, m1_RVALID}), 64'd0);
      s_RVALID = 1'b0;

      for (int v = 0; v < 6; v++) begin
         set_ar(vecs[v].mgr, 1'b1, vecs[v].id, vecs[v].addr);
         ar_hs(vecs[v].mgr, $sformatf("vec%0d", v));
         serve(vecs[v].mgr, vecs[v].id, vecs[v].addr, vecs[v].ar_stall, 0,
               vecs[v].data, vecs[v].resp, $sformatf("vec%0d", v));
      end

      // Back-pressure: m0 holds RREADY low 5 cycles while m1 waits.
      set_ar(0, 1'b1, 4'h4, 32'h8);
      ar_hs(0, "bp");
      set_ar(1, 1'b1, 4'h6, 32'h10);
      serve(0, 4'h4, 32'h8, 0, 5, 64'hCAFEBAB0F00DFACE, 2'b00, "bp_m0");
      ar_hs(1, "bp_next");
      serve(1, 4'h6, 32'h10, 0, 0, 64'h1122334455667788, 2'b00, "bp_m1");

      // Reset asserted mid-RESP abandons the read.
      set_ar(0, 1'b1, 4'h7, 32'h10);
      ar_hs(0, "mrst");
      s_ARREADY = 1'b1;
      @(posedge ACLK); @(negedge ACLK);
      s_ARREADY = 1'b0;
      s_RID = 4'h7; s_RDATA = 64'h1122334455667788; s_RRESP = 2'b00; s_RVALID = 1'b1;
      set_ar(1, 1'b1, 4'hB, 32'h8);
      #1;
      chk("mrst pre rvalid", 64'(m0_RVALID), 64'd1);
      #1 ARESETn = 1'b1;
      #1;
      chk("mrst rvalid", 64'({m0_RVALID, m1_RVALID}), 64'd0);
      chk("mrst s_rready", 64'(s_RREADY), 64'd0);
      chk("mrst arready", 64'({m0_ARREADY, m1_ARREADY}), 64'd0);
      chk("mrst s_arvalid", 64'(s_ARVALID), 64'd0);
      @(posedge ACLK); @(negedge ACLK);
      chk("mrst hold rvalid", 64'({m0_RVALID, m1_RVALID}), 64'd0);
      s_RVALID = 1'b0;
      ARESETn = 1'b0;
      ar_hs(1, "post_rst");
      serve(1, 4'hB, 32'h8, 0, 0, 64'hCAFEBAB0F00DFACE, 2'b00, "post_rst_m1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
